// File: rtl/apb_pkg.sv
// Shared state type and width helpers for the APB completer and its register file.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1
    } state_t;

    function automatic int strb_width(input int dw);
        return dw / 8;
    endfunction

    function automatic int offset_width(input int dw);
        return (dw / 8 > 1) ? $clog2(dw / 8) : 0;
    endfunction

    function automatic int index_width(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

endpackage

// File: rtl/apb_slv_regfile.sv
// NREG x DW register file: byte-strobed synchronous write, combinational read,
// asynchronous clear to zero.
module apb_slv_regfile
    import apb_pkg::*;
#(
    parameter int DW   = 32,
    parameter int NREG = 16,
    localparam int SW  = strb_width(DW),
    localparam int IW  = index_width(NREG)
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  logic [DW-1:0] wdata,
    input  logic [SW-1:0] wstrb,
    input  logic [IW-1:0] ridx,
    output logic [DW-1:0] rdata
);

    localparam logic [IW:0] NREG_W = (IW + 1)'(NREG);

    logic [DW-1:0] mem [NREG];

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int r = 0; r < NREG; r++) begin
                mem[r] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < SW; b++) begin
                if (wstrb[b]) begin
                    mem[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Indices past the last register exist when NREG is not a power of two.
    assign rdata = ({1'b0, ridx} < NREG_W) ? mem[ridx] : '0;

endmodule

// File: rtl/apb_slave.sv
// APB completer servicing a byte-strobed register file with WS wait states per transfer.
// Define APB_SLAVE_ERR_EN to answer out-of-range addresses with pslverr instead of aliasing.
module apb_slave
    import apb_pkg::*;
#(
    parameter int DW   = 32,
    parameter int AW   = 8,
    parameter int NREG = 16,
    parameter int WS   = 0,
    localparam int SW  = strb_width(DW)
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic [AW-1:0] i_paddr,
    input  logic          i_pwrite,
    input  logic          i_psel,
    input  logic          i_penable,
    input  logic [DW-1:0] i_pwdata,
    input  logic [SW-1:0] i_pstrb,
    output logic [DW-1:0] o_prdata,
    output logic          o_pslverr,
    output logic          o_pready
);

    localparam int AL = offset_width(DW);
    localparam int IW = index_width(NREG);
    localparam logic [IW:0] NREG_W = (IW + 1)'(NREG);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q;
    logic          write_q;
    logic [DW-1:0] wdata_q;
    logic [SW-1:0] strb_q;
    logic          capture, ready, done, err, rf_we;
    logic [IW-1:0] raw_idx, reg_idx;
    logic [DW-1:0] rf_rdata;
    logic          unused_addr;

    assign raw_idx     = addr_q[AL +: IW];
    assign unused_addr = ^addr_q;

`ifdef APB_SLAVE_ERR_EN
    logic [AW-1:0] addr_hi;
    assign addr_hi = addr_q >> (AL + IW);
    assign err     = (addr_hi != '0) || ({1'b0, raw_idx} >= NREG_W);
    assign reg_idx = raw_idx;
`else
    logic [IW:0] idx_mod;
    assign idx_mod = {1'b0, raw_idx} % NREG_W;
    assign reg_idx = idx_mod[IW-1:0];
    assign err     = 1'b0;
`endif

    // The wait counter only advances while penable is high, so a dropped penable stalls it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        ready   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_psel && !i_penable) begin
                    capture = 1'b1;
                    cnt_d   = 4'(WS);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    if (i_penable) begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end else begin
                    ready = 1'b1;
                    if (i_penable) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else if (capture) begin
            addr_q  <= i_paddr;
            write_q <= i_pwrite;
            wdata_q <= i_pwdata;
            strb_q  <= i_pstrb;
        end
    end

    assign rf_we     = done && write_q && !err;
    assign o_pready  = ready;
    assign o_pslverr = ready && err;
    assign o_prdata  = (ready && !write_q && !err) ? rf_rdata : '0;

    apb_slv_regfile #(
        .DW   (DW),
        .NREG (NREG)
    ) u_regfile (
        .pclk    (pclk),
        .presetn (presetn),
        .we      (rf_we),
        .widx    (reg_idx),
        .wdata   (wdata_q),
        .wstrb   (strb_q),
        .ridx    (reg_idx),
        .rdata   (rf_rdata)
    );

endmodule

// File: doc/apb_slave.md
# apb_slave

Completer-side APB block: decodes APB transfers from the APB master and services them against an internal byte-strobed register file, with a programmable number of wait states. It sits on the far end of the APB bus as the default peripheral model and as a generic configuration/status register bank.

## Interface
Parameters:
- DW, 32: data width; multiple of 8.
- AW, 8: address width; max 32.
- NREG, 16: number of DW-bit registers; ≥1.
- WS, 0: wait states inserted per transfer; 0..15.
- Derived: SW = DW/8 strobe width; AL = log2(SW) byte-offset bits; IW = max(1, log2(NREG)) index width.

Ports:
- pclk  in  1  clock; all logic on rising edge.
- presetn  in  1  asynchronous active-low reset.
- i_paddr  in  AW  byte address.
- i_pwrite  in  1  1 = write, 0 = read.
- i_psel  in  1  select.
- i_penable  in  1  enable (access phase).
- i_pwdata  in  DW  write data.
- i_pstrb  in  SW  write byte strobes.
- o_prdata  out  DW  read data.
- o_pslverr  out  1  transfer error.
- o_pready  out  1  transfer complete.

## Operation
- FSM states: IDLE, ACCESS (2-bit enum).
- IDLE: setup phase = i_psel & !i_penable. On setup, capture paddr, pwrite, pwdata, pstrb into registers, load wait counter with WS, go to ACCESS. Anything else: stay IDLE.
- ACCESS: access phase = i_penable (i_psel not required). While counter ≠ 0 and i_penable: decrement. Counter == 0: o_pready = 1 combinationally; if i_penable, transfer completes that cycle, return to IDLE.
- i_penable low in ACCESS: counter holds, no completion (stall).
- Word index = captured paddr[AL+:IW]; address bits [AL-1:0] ignored; bits above AL+IW participate only in range check.
- Write completion: for each byte b with pstrb[b]=1, reg[index][8b+:8] ← pwdata byte; other bytes unchanged. pstrb = 0 → no change, no error.
- Read completion: o_prdata = reg[index]; o_prdata = 0 whenever o_pready = 0.
- o_pslverr valid only with o_pready; 0 otherwise.
- Registers reset to 0; no other reset-visible state besides FSM/counter.

## Timing
- Reset values: o_pready 0, o_pslverr 0, o_prdata 0; state IDLE; counter 0; registers 0.
- Transfer length: setup + (WS + 1) access cycles; WS=0 → 2 cycles, o_pready in first access cycle.
- Write data visible in the register on the edge ending the completing cycle; a read setup in the next cycle returns it.
- Back-to-back: setup may occur in the cycle after completion; no idle cycle required.
- Setup while in ACCESS is ignored (protocol violation, no capture).
- Reset mid-transfer: aborts immediately, no register write, outputs to reset values.

## Configuration
- APB_SLAVE_ERR_EN defined: index ≥ NREG or any captured address bit above AL+IW set → o_pslverr = 1 at completion, write suppressed, o_prdata = 0.
- Undefined: o_pslverr tied 0; index taken modulo NREG (upper bits ignored); all accesses succeed.

## Structure
- Shared package apb_pkg: state_t enum (IDLE, ACCESS), strobe/index width functions.
- One sub-module apb_slv_regfile: NREG×DW array, byte-strobed write port, combinational read port, async reset to 0. FSM, counter, capture and error check stay in apb_slave.

## Test plan
(DW=32, AW=8, NREG=16, WS=2 unless noted)
- Write 0xDEADBEEF to 0x08, pstrb 0xF, then read 0x08 → o_pready in 3rd access cycle each; read returns 0xDEADBEEF, pslverr 0.
- Partial write 0x11223344 to 0x08 with pstrb 0x5 over 0xDEADBEEF → read returns 0xDE22BE44.
- WS=0: back-to-back write 0x04 then read 0x04 with no idle cycle → each transfer 2 cycles, read returns written data.
- ERR_EN defined, NREG=12: write to 0x30 (index 12) → pslverr 1, no register changes; read 0x30 → prdata 0, pslverr 1. ERR_EN undefined, NREG=16: write 0x44 aliases index 1.
- Drop i_penable for 2 cycles mid-ACCESS → counter holds, o_pready delayed by 2 cycles, data correct.
- Assert presetn low during ACCESS of a write → register unchanged, outputs 0, next transfer proceeds normally.
